// File: rtl/matrix_mult_seq_ctrl.sv
// -----------------------------------------------------------------------------
// matrix_mult_seq_ctrl
//   Time-multiplexed N x N unsigned matrix multiplier computing C = A * B with a
//   single multiply-accumulate unit. An i/j/k loop FSM walks the result in
//   row-major order (k fastest) and retires one product term per clock.
//   Its flattened operand/result layout matches the combinational multiplier,
//   so callers can swap between the two.
//
// Ports
//   clk     in   1        rising-edge clock
//   rst     in   1        synchronous reset, active high, highest priority
//   start   in   1        request; accepted in IDLE, or on the edge ending DONE
//   A_flat  in   N*N*DW   A[i][j] at bits [(i*N+j)*DW +: DW]
//   B_flat  in   N*N*DW   B[i][j] at bits [(i*N+j)*DW +: DW]
//   busy    out  1        high while the MAC loop runs
//   done    out  1        one-cycle pulse; C_flat is complete
//   C_flat  out  N*N*AW   C[i][j] at bits [(i*N+j)*AW +: AW]
// -----------------------------------------------------------------------------
module matrix_mult_seq_ctrl #(
  parameter  int N  = 3,
  parameter  int DW = 8,
  localparam int AW = 2 * DW + $clog2(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [N*N*DW-1:0] A_flat,
  input  logic [N*N*DW-1:0] B_flat,
  output logic              busy,
  output logic              done,
  output logic [N*N*AW-1:0] C_flat
);

  // Loop counters need at least one bit even when N == 1.
  localparam int            CW   = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   i_q, i_d;
  logic [CW-1:0]   j_q, j_d;
  logic [CW-1:0]   k_q, k_d;
  logic [AW-1:0]   acc_q, acc_d;
  logic            busy_q;
  logic            done_q;

  // Captured operands, so input changes after acceptance do not disturb a run.
  logic [DW-1:0]   a_q [N][N];
  logic [DW-1:0]   b_q [N][N];
  logic [AW-1:0]   c_q [N][N];

  logic            load_s;
  logic            c_we_s;
  logic [2*DW-1:0] prod_s;
  logic [AW-1:0]   sum_s;

  // Single MAC: the first term of each dot product ignores the stale accumulator.
  assign prod_s = (2*DW)'(a_q[i_q][k_q]) * (2*DW)'(b_q[k_q][j_q]);
  assign sum_s  = ((k_q == {CW{1'b0}}) ? {AW{1'b0}} : acc_q) + AW'(prod_s);

  // Next-state logic for the i/j/k loop sequencer.
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    acc_d   = acc_q;
    load_s  = 1'b0;
    c_we_s  = 1'b0;
    case (state_q)
      // DONE also accepts start so a held request restarts without an idle gap.
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_RUN;
          load_s  = 1'b1;
          i_d     = {CW{1'b0}};
          j_d     = {CW{1'b0}};
          k_d     = {CW{1'b0}};
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        acc_d = sum_s;
        if (k_q == LAST) begin
          c_we_s = 1'b1;
          k_d    = {CW{1'b0}};
          if (j_q == LAST) begin
            j_d = {CW{1'b0}};
            if (i_q == LAST) begin
              i_d     = {CW{1'b0}};
              state_d = ST_DONE;
            end else begin
              i_d = i_q + CW'(1);
            end
          end else begin
            j_d = j_q + CW'(1);
          end
        end else begin
          k_d = k_q + CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control state, loop counters, accumulator and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      i_q     <= {CW{1'b0}};
      j_q     <= {CW{1'b0}};
      k_q     <= {CW{1'b0}};
      acc_q   <= {AW{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      busy_q  <= (state_d == ST_RUN);
      done_q  <= (state_d == ST_DONE);
    end
  end

  // Operand capture on the accepting edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          a_q[r][c] <= {DW{1'b0}};
          b_q[r][c] <= {DW{1'b0}};
        end
      end
    end else if (load_s) begin
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          a_q[r][c] <= A_flat[(r*N+c)*DW +: DW];
          b_q[r][c] <= B_flat[(r*N+c)*DW +: DW];
        end
      end
    end else begin
      a_q <= a_q;
      b_q <= b_q;
    end
  end

  // Result store: each element is written when its dot product completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          c_q[r][c] <= {AW{1'b0}};
        end
      end
    end else if (c_we_s) begin
      c_q[i_q][j_q] <= sum_s;
    end else begin
      c_q <= c_q;
    end
  end

  // Flatten the result array onto the output bus.
  for (genvar gr = 0; gr < N; gr++) begin : g_row
    for (genvar gc = 0; gc < N; gc++) begin : g_col
      assign C_flat[(gr*N+gc)*AW +: AW] = c_q[gr][gc];
    end
  end

  assign busy = busy_q;
  assign done = done_q;

endmodule
